// File: rtl/lc4_writeback_arbiter.sv
// Purpose: shares the single regfile/NZP writeback port between ALU (A) and load (L) completions.
// Latency: 1 cycle from acceptance to W_* (registered outputs).
// Backpressure: the loser of a contested cycle parks in a 1-entry slot; X_stall mirrors slot occupancy.
//
// Ports:
//   clk, rst_n (async, active-low), flush (sync discard of all in-flight results)
//   A_*/L_*   : valid + rob_index, prd, rddata, pc_redirect, regfile_we, nzp_we per source
//   A_stall/L_stall : source must hold its result (its slot is full)
//   W_*       : granted writeback beat; W_src 0=ALU 1=load; W_nzp derived from W_rddata
//   conflict_cnt : saturating count of contested cycles
module lc4_writeback_arbiter #(
  parameter int DATA_W = 16,
  parameter int ROB_W  = 2,
  parameter int PRD_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              A_valid,
  input  logic [ROB_W-1:0]  A_rob_index,
  input  logic [PRD_W-1:0]  A_prd,
  input  logic [DATA_W-1:0] A_rddata,
  input  logic [DATA_W-1:0] A_pc_redirect,
  input  logic              A_regfile_we,
  input  logic              A_nzp_we,
  input  logic              L_valid,
  input  logic [ROB_W-1:0]  L_rob_index,
  input  logic [PRD_W-1:0]  L_prd,
  input  logic [DATA_W-1:0] L_rddata,
  input  logic [DATA_W-1:0] L_pc_redirect,
  input  logic              L_regfile_we,
  input  logic              L_nzp_we,
  output logic              A_stall,
  output logic              L_stall,
  output logic              W_valid,
  output logic              W_src,
  output logic [ROB_W-1:0]  W_rob_index,
  output logic [PRD_W-1:0]  W_prd,
  output logic [DATA_W-1:0] W_rddata,
  output logic [DATA_W-1:0] W_pc_redirect,
  output logic [2:0]        W_nzp,
  output logic              W_regfile_we,
  output logic              W_nzp_we,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [PRD_W-1:0]  prd;
    logic [DATA_W-1:0] rddata;
    logic [DATA_W-1:0] pc;
    logic              rf_we;
    logic              nzp_we;
  } pl_t;

  pl_t              w_a_in, w_l_in;
  pl_t              w_a_pl, w_l_pl, w_grant_pl;
  logic             w_a_cand, w_l_cand, w_both, w_any, w_sel_l;

  logic             r_a_slot_vld, r_l_slot_vld;
  pl_t              r_a_slot, r_l_slot;
  logic             r_prio;
  logic [CNT_W-1:0] r_cnt;
  logic             r_w_vld;
  logic             r_w_src;
  pl_t              r_w_pl;

  assign w_a_in = '{rob: A_rob_index, prd: A_prd, rddata: A_rddata, pc: A_pc_redirect,
                    rf_we: A_regfile_we, nzp_we: A_nzp_we};
  assign w_l_in = '{rob: L_rob_index, prd: L_prd, rddata: L_rddata, pc: L_pc_redirect,
                    rf_we: L_regfile_we, nzp_we: L_nzp_we};

  // A parked entry is older than anything on the input, and the input is
  // ignored while the slot is full, so the slot always wins the candidacy.
  assign w_a_cand = r_a_slot_vld | A_valid;
  assign w_l_cand = r_l_slot_vld | L_valid;
  assign w_a_pl   = r_a_slot_vld ? r_a_slot : w_a_in;
  assign w_l_pl   = r_l_slot_vld ? r_l_slot : w_l_in;

  assign w_both     = w_a_cand & w_l_cand;
  assign w_any      = w_a_cand | w_l_cand;
  // L wins when it is alone, or when contested and priority points at it.
  assign w_sel_l    = w_l_cand & (~w_a_cand | r_prio);
  assign w_grant_pl = w_sel_l ? w_l_pl : w_a_pl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_slot_vld <= 1'b0;
      r_l_slot_vld <= 1'b0;
      r_a_slot     <= '0;
      r_l_slot     <= '0;
      r_prio       <= 1'b0;
      r_cnt        <= '0;
      r_w_vld      <= 1'b0;
      r_w_src      <= 1'b0;
      r_w_pl       <= '0;
    end else if (flush) begin
      // Everything in flight is discarded; arbitration history survives.
      r_a_slot_vld <= 1'b0;
      r_l_slot_vld <= 1'b0;
      r_w_vld      <= 1'b0;
    end else begin
      // A slot is full next cycle exactly when its source lost this cycle;
      // a losing slot entry simply reloads itself, a winning one frees.
      r_a_slot_vld <= w_a_cand & w_sel_l;
      r_l_slot_vld <= w_l_cand & ~w_sel_l;
      if (w_a_cand & w_sel_l) r_a_slot <= w_a_pl;
      if (w_l_cand & ~w_sel_l) r_l_slot <= w_l_pl;

      if (w_both) begin
        r_prio <= ~w_sel_l;  // point at the loser so it wins next time
        if (~&r_cnt) r_cnt <= r_cnt + 1'b1;
      end

      r_w_vld <= w_any;
      if (w_any) begin
        r_w_src <= w_sel_l;
        r_w_pl  <= w_grant_pl;
      end
    end
  end

  assign A_stall       = r_a_slot_vld;
  assign L_stall       = r_l_slot_vld;
  assign W_valid       = r_w_vld;
  assign W_src         = r_w_src;
  assign W_rob_index   = r_w_pl.rob;
  assign W_prd         = r_w_pl.prd;
  assign W_rddata      = r_w_pl.rddata;
  assign W_pc_redirect = r_w_pl.pc;
  assign W_regfile_we  = r_w_pl.rf_we & r_w_vld;
  assign W_nzp_we      = r_w_pl.nzp_we & r_w_vld;
  assign conflict_cnt  = r_cnt;

  always_comb begin
    W_nzp = 3'b001;
    if (r_w_pl.rddata == '0)          W_nzp = 3'b010;
    else if (r_w_pl.rddata[DATA_W-1]) W_nzp = 3'b100;
  end

endmodule

// File: tb/tb_lc4_writeback_arbiter.sv
module tb_lc4_writeback_arbiter;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, flush;
  logic A_valid, A_regfile_we, A_nzp_we, L_valid, L_regfile_we, L_nzp_we;
  logic [1:0] A_rob_index, L_rob_index;
  logic [3:0] A_prd, L_prd;
  logic [15:0] A_rddata, A_pc_redirect, L_rddata, L_pc_redirect;
  logic A_stall, L_stall, W_valid, W_src, W_regfile_we, W_nzp_we;
  logic [1:0] W_rob_index;
  logic [3:0] W_prd;
  logic [15:0] W_rddata, W_pc_redirect;
  logic [2:0] W_nzp;
  logic [CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  lc4_writeback_arbiter #(.DATA_W(16), .ROB_W(2), .PRD_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .A_valid(A_valid), .A_rob_index(A_rob_index), .A_prd(A_prd), .A_rddata(A_rddata),
    .A_pc_redirect(A_pc_redirect), .A_regfile_we(A_regfile_we), .A_nzp_we(A_nzp_we),
    .L_valid(L_valid), .L_rob_index(L_rob_index), .L_prd(L_prd), .L_rddata(L_rddata),
    .L_pc_redirect(L_pc_redirect), .L_regfile_we(L_regfile_we), .L_nzp_we(L_nzp_we),
    .A_stall(A_stall), .L_stall(L_stall), .W_valid(W_valid), .W_src(W_src),
    .W_rob_index(W_rob_index), .W_prd(W_prd), .W_rddata(W_rddata), .W_pc_redirect(W_pc_redirect),
    .W_nzp(W_nzp), .W_regfile_we(W_regfile_we), .W_nzp_we(W_nzp_we), .conflict_cnt(conflict_cnt)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  rob;
    logic [3:0]  prd;
    logic [15:0] d;
    logic [15:0] pc;
    logic        rf;
    logic        nz;
  } pl_t;

  pl_t held_a[$], held_l[$];   // results a source has handed over but not yet written back
  bit  m_prio;
  int  m_cnt;
  bit  e_vld, e_src;
  pl_t e_pl;

  function automatic logic [2:0] nzp_of(input logic [15:0] d);
    if (d == 16'h0) return 3'b010;
    if (d[15])      return 3'b100;
    return 3'b001;
  endfunction

  always @(negedge rst_n) begin
    held_a.delete(); held_l.delete();
    m_prio = 0; m_cnt = 0; e_vld = 0; e_src = 0; e_pl = '0;
  end

  always @(posedge clk) begin
    pl_t ca, cl;
    bit  ha, hl, qa, ql, win_l;
    if (rst_n) begin
      ha = 0; hl = 0; qa = 0; ql = 0; ca = '0; cl = '0;
      if (held_a.size() > 0) begin ca = held_a[0]; ha = 1; qa = 1; end
      else if (A_valid) begin
        ca = '{A_rob_index, A_prd, A_rddata, A_pc_redirect, A_regfile_we, A_nzp_we}; ha = 1;
      end
      if (held_l.size() > 0) begin cl = held_l[0]; hl = 1; ql = 1; end
      else if (L_valid) begin
        cl = '{L_rob_index, L_prd, L_rddata, L_pc_redirect, L_regfile_we, L_nzp_we}; hl = 1;
      end
      if (flush) begin
        held_a.delete(); held_l.delete(); e_vld = 0;
      end else if (ha || hl) begin
        win_l = (ha && hl) ? m_prio : hl;
        if (ha && hl) begin
          m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
          m_prio = !win_l;
          if (win_l && !qa) held_a.push_back(ca);
          if (!win_l && !ql) held_l.push_back(cl);
        end
        if (win_l && ql) void'(held_l.pop_front());
        if (!win_l && qa) void'(held_a.pop_front());
        e_vld = 1; e_src = win_l; e_pl = win_l ? cl : ca;
      end else begin
        e_vld = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_W_valid", W_valid, e_vld);
      chk("m_A_stall", A_stall, held_a.size() != 0);
      chk("m_L_stall", L_stall, held_l.size() != 0);
      chk("m_conflict_cnt", conflict_cnt, m_cnt);
      chk("m_W_regfile_we", W_regfile_we, e_vld & e_pl.rf);
      chk("m_W_nzp_we", W_nzp_we, e_vld & e_pl.nz);
      if (e_vld) begin
        chk("m_W_src", W_src, e_src);
        chk("m_W_rob", W_rob_index, e_pl.rob);
        chk("m_W_prd", W_prd, e_pl.prd);
        chk("m_W_rddata", W_rddata, e_pl.d);
        chk("m_W_pc", W_pc_redirect, e_pl.pc);
        chk("m_W_nzp", W_nzp, nzp_of(e_pl.d));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic set_a(input logic [1:0] r, input logic [3:0] p, input logic [15:0] d,
                       input logic [15:0] pc, input logic rf, input logic nz);
    A_valid = 1; A_rob_index = r; A_prd = p; A_rddata = d; A_pc_redirect = pc;
    A_regfile_we = rf; A_nzp_we = nz;
  endtask

  task automatic set_l(input logic [1:0] r, input logic [3:0] p, input logic [15:0] d,
                       input logic [15:0] pc, input logic rf, input logic nz);
    L_valid = 1; L_rob_index = r; L_prd = p; L_rddata = d; L_pc_redirect = pc;
    L_regfile_we = rf; L_nzp_we = nz;
  endtask

  task automatic clr();
    A_valid = 0; A_rob_index = 0; A_prd = 0; A_rddata = 0; A_pc_redirect = 0;
    A_regfile_we = 0; A_nzp_we = 0;
    L_valid = 0; L_rob_index = 0; L_prd = 0; L_rddata = 0; L_pc_redirect = 0;
    L_regfile_we = 0; L_nzp_we = 0;
  endtask

  logic [15:0] exp_d3 [5];
  logic        exp_s3 [5];

  initial begin
    rst_n = 0; flush = 0; clr();
    #12;
    chk("rst_W_valid", W_valid, 0);
    chk("rst_W_nzp", W_nzp, 3'b010);
    chk("rst_A_stall", A_stall, 0);
    chk("rst_L_stall", L_stall, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_W_rddata", W_rddata, 0);
    cyc(); rst_n = 1;
    cyc();

    // 1: lone ALU result, negative value
    set_a(2'd1, 4'd3, 16'h8000, 16'h0040, 1, 1);
    cyc(); clr();
    chk("t1_W_valid", W_valid, 1);
    chk("t1_W_src", W_src, 0);
    chk("t1_W_nzp", W_nzp, 3'b100);
    chk("t1_W_prd", W_prd, 4'd3);
    chk("t1_W_rob", W_rob_index, 2'd1);
    chk("t1_A_stall", A_stall, 0);
    cyc();
    chk("t1_idle_W_valid", W_valid, 0);

    // 2: first collision, ALU preferred
    set_a(2'd2, 4'd5, 16'h1234, 16'h0100, 1, 0);
    set_l(2'd3, 4'd6, 16'hFFFF, 16'h0200, 1, 1);
    cyc(); clr();
    chk("t2_c1_W_src", W_src, 0);
    chk("t2_c1_W_rddata", W_rddata, 16'h1234);
    chk("t2_c1_L_stall", L_stall, 1);
    cyc();
    chk("t2_c2_W_valid", W_valid, 1);
    chk("t2_c2_W_src", W_src, 1);
    chk("t2_c2_L_stall", L_stall, 0);
    chk("t2_c2_cnt", conflict_cnt, 1);
    chk("t2_c2_W_nzp", W_nzp, 3'b100);
    cyc();

    // 6: load with only NZP write, zero data
    set_l(2'd0, 4'd7, 16'h0000, 16'h0300, 0, 1);
    cyc(); clr();
    chk("t6_W_src", W_src, 1);
    chk("t6_W_regfile_we", W_regfile_we, 0);
    chk("t6_W_nzp_we", W_nzp_we, 1);
    chk("t6_W_nzp", W_nzp, 3'b010);
    cyc();

    // 4: park an L result, then flush it (prio is 1 here)
    set_a(2'd1, 4'd1, 16'h0011, 16'h0400, 1, 1);
    set_l(2'd2, 4'd2, 16'h0022, 16'h0500, 1, 1);
    cyc();
    chk("t4_c1_W_src", W_src, 1);
    chk("t4_c1_A_stall", A_stall, 1);
    A_valid = 0;
    set_l(2'd3, 4'd9, 16'h0099, 16'h0600, 1, 1);
    cyc(); clr();
    chk("t4_c2_W_src", W_src, 0);
    chk("t4_c2_W_rddata", W_rddata, 16'h0011);
    chk("t4_c2_L_stall", L_stall, 1);
    chk("t4_c2_cnt_sat", conflict_cnt, 3);
    flush = 1;
    cyc(); flush = 0;
    chk("t4_fl_W_valid", W_valid, 0);
    chk("t4_fl_L_stall", L_stall, 0);
    cyc();
    chk("t4_after_W_valid", W_valid, 0);
    chk("t4_after_cnt", conflict_cnt, 3);

    // 5: async reset while A is parked (prio is 1 here)
    set_a(2'd0, 4'd4, 16'h0044, 16'h0700, 1, 1);
    set_l(2'd1, 4'd8, 16'h0088, 16'h0800, 1, 1);
    cyc(); clr();
    chk("t5_A_stall", A_stall, 1);
    #1 rst_n = 0;
    #1;
    chk("t5_W_valid", W_valid, 0);
    chk("t5_A_stall_rst", A_stall, 0);
    chk("t5_cnt", conflict_cnt, 0);
    chk("t5_W_nzp", W_nzp, 3'b010);
    chk("t5_W_rob", W_rob_index, 0);
    cyc(); rst_n = 1;

    // 3: both sources streaming, rotating grants
    exp_s3 = '{0, 1, 0, 1, 0};
    exp_d3 = '{16'h0100, 16'h0200, 16'h0101, 16'h0202, 16'h0103};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        set_a(i[1:0], i[3:0], 16'h0100 + 16'(i), 16'h0A00, 1, 1);
        set_l(i[1:0], 4'd8 + i[3:0], 16'h0200 + 16'(i), 16'h0B00, 1, 0);
      end else clr();
      cyc();
      chk($sformatf("t3_src_%0d", i), W_src, exp_s3[i]);
      chk($sformatf("t3_data_%0d", i), W_rddata, exp_d3[i]);
    end
    clr();
    chk("t3_cnt_sat", conflict_cnt, 3);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
